// File: rtl/sid_envelope_gen.sv
// ---------------------------------------------------------------------------
// sid_envelope_gen
//
// One SID-style ADSR envelope generator for a single voice. It produces the
// 8-bit unsigned envelope level that scales the voice waveform in the
// 12x8 voice x envelope multiplier (iEnv input).
//
// The envelope steps only on SID ticks (iClkEn, nominally 1 MHz).
// Attack is linear. Decay and release are slowed by an exponential
// prescaler whose period depends on the current level, approximating the
// original chip's piecewise-exponential curve.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   iClkEn    SID tick enable; every state change is qualified by it
//   iGate     voice gate bit (rising edge -> attack, falling edge -> release)
//   iAttack   attack rate index
//   iDecay    decay rate index
//   iSustain  sustain level nibble (level = {iSustain, iSustain})
//   iRelease  release rate index
//   oEnv      envelope level, registered
//   oState    0 = ATTACK, 1 = DECAY_SUSTAIN, 2 = RELEASE
// ---------------------------------------------------------------------------
module sid_envelope_gen #(
    parameter int RATE_W = 15,
    parameter int EXP_W  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iClkEn,
    input  logic       iGate,
    input  logic [3:0] iAttack,
    input  logic [3:0] iDecay,
    input  logic [3:0] iSustain,
    input  logic [3:0] iRelease,
    output logic [7:0] oEnv,
    output logic [1:0] oState
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic [RATE_W-1:0]  r_rate_cnt;
    logic [EXP_W-1:0]   r_exp_cnt;
    logic [EXP_W-1:0]   r_exp_per;
    logic               r_gate;
    logic [7:0]         r_env;

    logic [3:0]         w_nibble;
    logic [RATE_W-1:0]  w_period;
    logic               w_rate_evt;
    logic [EXP_W-1:0]   w_exp_next;
    logic               w_exp_hit;
    logic [7:0]         w_target;
    logic [7:0]         w_env_inc;
    logic [7:0]         w_env_dec;
    logic               w_gate_rise;
    logic               w_gate_fall;

    // Ticks per envelope step for each rate index.
    function automatic logic [RATE_W-1:0] rate_rom(input logic [3:0] idx);
        logic [RATE_W-1:0] v;
        case (idx)
            4'd0:    v = RATE_W'(9);
            4'd1:    v = RATE_W'(32);
            4'd2:    v = RATE_W'(63);
            4'd3:    v = RATE_W'(95);
            4'd4:    v = RATE_W'(149);
            4'd5:    v = RATE_W'(220);
            4'd6:    v = RATE_W'(267);
            4'd7:    v = RATE_W'(313);
            4'd8:    v = RATE_W'(392);
            4'd9:    v = RATE_W'(977);
            4'd10:   v = RATE_W'(1954);
            4'd11:   v = RATE_W'(3126);
            4'd12:   v = RATE_W'(3907);
            4'd13:   v = RATE_W'(11720);
            4'd14:   v = RATE_W'(19532);
            default: v = RATE_W'(31251);
        endcase
        return v;
    endfunction

    // Exponential prescale period chosen by the level just written. Only the
    // breakpoint levels change it; everything in between keeps the old one,
    // so the period is sticky across a whole segment of the curve.
    function automatic logic [EXP_W-1:0] exp_period(input logic [7:0]       lvl,
                                                    input logic [EXP_W-1:0] cur);
        logic [EXP_W-1:0] v;
        case (lvl)
            8'hFF:   v = EXP_W'(1);
            8'h5D:   v = EXP_W'(2);
            8'h36:   v = EXP_W'(4);
            8'h1A:   v = EXP_W'(8);
            8'h0E:   v = EXP_W'(16);
            8'h06:   v = EXP_W'(30);
            8'h00:   v = EXP_W'(1);
            default: v = cur;
        endcase
        return v;
    endfunction

    always_comb begin
        case (r_state)
            ST_ATTACK: w_nibble = iAttack;
            ST_DECAY:  w_nibble = iDecay;
            default:   w_nibble = iRelease;
        endcase
    end

    assign w_period    = rate_rom(w_nibble);
    // Exact compare on purpose: if a rate change leaves the counter above
    // period-1 it must run all the way round before the next step.
    assign w_rate_evt  = (r_rate_cnt == (w_period - 1'b1));
    assign w_exp_next  = r_exp_cnt + 1'b1;
    assign w_exp_hit   = (w_exp_next == r_exp_per);
    assign w_target    = (r_state == ST_DECAY) ? {iSustain, iSustain} : 8'h00;
    assign w_env_inc   = r_env + 8'd1;
    assign w_env_dec   = r_env - 8'd1;
    assign w_gate_rise = iGate & ~r_gate;
    assign w_gate_fall = ~iGate & r_gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RELEASE;
            r_rate_cnt <= '0;
            r_exp_cnt  <= '0;
            r_exp_per  <= EXP_W'(1);
            r_gate     <= 1'b0;
            r_env      <= 8'h00;
        end else if (iClkEn) begin
            r_gate <= iGate;
            // Gate edges win over any step that would fall on the same tick.
            if (w_gate_rise) begin
                r_state    <= ST_ATTACK;
                r_rate_cnt <= '0;
            end else if (w_gate_fall) begin
                r_state    <= ST_RELEASE;
                r_rate_cnt <= '0;
            end else if (w_rate_evt) begin
                r_rate_cnt <= '0;
                case (r_state)
                    ST_ATTACK: begin
                        r_exp_cnt <= '0;
                        // Saturate at full scale: a retrigger at 0xFF moves
                        // straight to decay instead of wrapping to zero.
                        if (r_env != 8'hFF) begin
                            r_env     <= w_env_inc;
                            r_exp_per <= exp_period(w_env_inc, r_exp_per);
                        end
                        if (r_env >= 8'hFE) begin
                            r_state <= ST_DECAY;
                        end
                    end
                    default: begin
                        if (w_exp_hit) begin
                            r_exp_cnt <= '0;
                            // Strictly above target: a sustain raised over the
                            // current level holds rather than climbing.
                            if (r_env > w_target) begin
                                r_env     <= w_env_dec;
                                r_exp_per <= exp_period(w_env_dec, r_exp_per);
                            end
                        end else begin
                            r_exp_cnt <= w_exp_next;
                        end
                    end
                endcase
            end else begin
                r_rate_cnt <= r_rate_cnt + 1'b1;
            end
        end
    end

    assign oEnv   = r_env;
    assign oState = r_state;

endmodule

// File: tb/tb_sid_envelope_gen.sv
module tb_sid_envelope_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       iClkEn;
    logic       iGate;
    logic [3:0] iAttack;
    logic [3:0] iDecay;
    logic [3:0] iSustain;
    logic [3:0] iRelease;
    logic [7:0] oEnv;
    logic [1:0] oState;

    always #5 clk = ~clk;

    sid_envelope_gen #(.RATE_W(15), .EXP_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .iClkEn   (iClkEn),
        .iGate    (iGate),
        .iAttack  (iAttack),
        .iDecay   (iDecay),
        .iSustain (iSustain),
        .iRelease (iRelease),
        .oEnv     (oEnv),
        .oState   (oState)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0] env;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: envelope level, phase, ticks elapsed in the current
    // step, prescale progress and the level-dependent prescale divisor.
    int rates[16] = '{9, 32, 63, 95, 149, 220, 267, 313,
                      392, 977, 1954, 3126, 3907, 11720, 19532, 31251};
    int m_env, m_state, m_cnt, m_ecnt, m_eper, m_gate;

    task automatic model_reset();
        m_env = 0; m_state = 2; m_cnt = 0; m_ecnt = 0; m_eper = 1; m_gate = 0;
    endtask

    function automatic int divisor_for(input int lvl, input int prev);
        if (lvl == 255) return 1;
        if (lvl == 93)  return 2;
        if (lvl == 54)  return 4;
        if (lvl == 26)  return 8;
        if (lvl == 14)  return 16;
        if (lvl == 6)   return 30;
        if (lvl == 0)   return 1;
        return prev;
    endfunction

    task automatic model_clock();
        int per;
        int tgt;
        int nib;
        if (rst) begin
            model_reset();
            return;
        end
        if (!iClkEn) return;
        if (int'(iGate) != m_gate) begin
            m_state = iGate ? 0 : 2;
            m_cnt   = 0;
            m_gate  = int'(iGate);
            return;
        end
        nib = (m_state == 0) ? int'(iAttack) : (m_state == 1) ? int'(iDecay) : int'(iRelease);
        per = rates[nib];
        if (m_cnt != per - 1) begin
            m_cnt = (m_cnt + 1) % 32768;
            return;
        end
        m_cnt = 0;
        if (m_state == 0) begin
            m_ecnt = 0;
            if (m_env < 255) begin
                m_env  = m_env + 1;
                m_eper = divisor_for(m_env, m_eper);
            end
            if (m_env == 255) m_state = 1;
        end else begin
            m_ecnt = m_ecnt + 1;
            if (m_ecnt == m_eper) begin
                m_ecnt = 0;
                tgt = (m_state == 1) ? 17 * int'(iSustain) : 0;
                if (m_env > tgt) begin
                    m_env  = m_env - 1;
                    m_eper = divisor_for(m_env, m_eper);
                end
            end
        end
    endtask

    // Inputs are applied at the falling edge; the model predicts the state
    // after the coming rising edge and queues it for the monitor.
    task automatic cyc(input logic en);
        exp_t e;
        iClkEn = en;
        model_clock();
        e.env = 8'(m_env);
        e.st  = 2'(m_state);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_change(input int max_ticks, output int ticks);
        logic [7:0] prev;
        prev  = oEnv;
        ticks = 0;
        do begin
            cyc(1'b1);
            ticks++;
        end while (oEnv == prev && ticks < max_ticks);
    endtask

    task automatic run_until(input logic [7:0] lvl, input int max_ticks);
        int c;
        c = 0;
        while (oEnv != lvl && c < max_ticks) begin
            cyc(1'b1);
            c++;
        end
    endtask

    // Monitor: the DUT presents a new registered output after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({oState, oEnv} !== {e.st, e.env}) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got env=%02h st=%0d, expected env=%02h st=%0d",
                             $time, oEnv, oState, e.env, e.st);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        int c, t1, t2, n;
        logic [7:0] prev;

        rst = 1'b1; iClkEn = 1'b0; iGate = 1'b0;
        iAttack = 4'd0; iDecay = 4'd0; iSustain = 4'hF; iRelease = 4'd0;
        model_reset();
        repeat (3) cyc(1'b1);
        check("reset_env", int'(oEnv), 0);
        check("reset_state", int'(oState), 2);
        rst = 1'b0;

        // Attack sweep from zero at the fastest rate.
        iGate = 1'b1;
        cyc(1'b1);
        c = 0;
        while (oEnv != 8'hFF && c < 3000) begin
            cyc(1'b1);
            c++;
        end
        check_rng("attack_ticks", c, 2294, 2296);
        check("attack_state", int'(oState), 1);
        repeat (50) cyc(1'b1);
        check("attack_hold", int'(oEnv), 255);

        // Decay to sustain 0x88.
        iSustain = 4'h8;
        wait_change(200, t1);
        wait_change(200, t2);
        check("decay_step_iv", t2, 9);
        run_until(8'h88, 2000);
        check("decay_level", int'(oEnv), 8'h88);
        repeat (200) cyc(1'b1);
        check("sustain_hold", int'(oEnv), 8'h88);
        iSustain = 4'hC;
        repeat (100) cyc(1'b1);
        check("sustain_raise_hold", int'(oEnv), 8'h88);

        // Release to zero, checking the prescale slowdown at each breakpoint.
        iGate = 1'b0;
        cyc(1'b1);
        check("release_state", int'(oState), 2);
        prev = oEnv; n = 0; c = 0;
        while (oEnv != 8'h00 && c < 8000) begin
            cyc(1'b1);
            c++; n++;
            if (oEnv != prev) begin
                check("release_monotonic", int'(oEnv), int'(prev) - 1);
                case (prev)
                    8'h5E: check("rel_iv_5E", n, 9);
                    8'h5D: check("rel_iv_5D", n, 18);
                    8'h36: check("rel_iv_36", n, 36);
                    8'h1A: check("rel_iv_1A", n, 72);
                    8'h0E: check("rel_iv_0E", n, 144);
                    8'h06: check("rel_iv_06", n, 270);
                    default: ;
                endcase
                prev = oEnv;
                n = 0;
            end
        end
        check("release_zero", int'(oEnv), 0);
        repeat (300) cyc(1'b1);
        check("release_hold", int'(oEnv), 0);

        // Retrigger mid-release at 0x40.
        iGate = 1'b1;
        cyc(1'b1);
        run_until(8'h60, 2000);
        iGate = 1'b0;
        cyc(1'b1);
        run_until(8'h40, 4000);
        check("retrig_pre", int'(oEnv), 8'h40);
        iGate = 1'b1;
        cyc(1'b1);
        check("retrig_state", int'(oState), 0);
        check("retrig_start", int'(oEnv), 8'h40);
        wait_change(20, t1);
        check("retrig_up", int'(oEnv), 8'h41);
        check("retrig_iv", t1, 9);

        // Clock enable held low mid-attack.
        repeat (1000) cyc(1'b0);
        check("clken_hold_env", int'(oEnv), 8'h41);
        check("clken_hold_state", int'(oState), 0);

        // Reset mid-decay.
        run_until(8'hFF, 3000);
        iSustain = 4'h8;
        repeat (300) cyc(1'b1);
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        check("midrst_env", int'(oEnv), 0);
        check("midrst_state", int'(oState), 2);

        // Rate change leaves the counter above the new period: full wrap.
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        iAttack = 4'd15;
        iGate = 1'b1;
        repeat (1001) cyc(1'b1);
        check("wrap_env_pre", int'(oEnv), 0);
        iAttack = 4'd0;
        wait_change(33000, t1);
        check_rng("wrap_ticks", t1, 31767, 31787);
        wait_change(20, t2);
        check("wrap_iv", t2, 9);

        // Randomised phase against the reference model.
        iAttack = 4'd1; iDecay = 4'd2; iRelease = 4'd1; iSustain = 4'h6;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 699) == 0) iGate = ~iGate;
            if ($urandom_range(0, 999) == 0) iAttack  = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) iDecay   = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) iRelease = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) iSustain = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 4999) == 0);
            cyc($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
